// File: rtl/debounce_array.sv
// debounce_array: multi-channel push-button / slide-switch synchroniser and debounce filter.
// Define DEBOUNCE_LONGPRESS_RST_EN to build the long-press reset request on btn_out[0].

module debounce_chan #(
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // A differing sample on the final count flips the level this edge.
    assign accept = (s != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            rise  <= accept && s;
            fall  <= accept && !s;
            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module debounce_array #(
    parameter int N_BTN         = 4,
    parameter int N_SW          = 8,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 1000000,
    parameter int LONG_W        = 28,
    parameter int LONG_CYCLES   = 200000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic [N_SW-1:0]  sw,
    output logic [N_BTN-1:0] btn_out,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_out,
    output logic             rst_out
);
    // Switch lanes share the button filter; their edge strobes are simply dropped.
    logic [N_SW-1:0] sw_rise_unused;
    logic [N_SW-1:0] sw_fall_unused;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_chan #(
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn[i]),
            .level(btn_out[i]),
            .rise (btn_press[i]),
            .fall (btn_release[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_chan #(
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .raw  (sw[i]),
            .level(sw_out[i]),
            .rise (sw_rise_unused[i]),
            .fall (sw_fall_unused[i])
        );
    end

`ifdef DEBOUNCE_LONGPRESS_RST_EN
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] lcnt;

    // Once raised, rst_out latches until btn_out[0] drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt    <= '0;
            rst_out <= 1'b0;
        end else begin
            if (!btn_out[0]) begin
                lcnt <= '0;
            end else if (lcnt != LONG_MAX) begin
                lcnt <= lcnt + 1'b1;
            end
            rst_out <= btn_out[0] && ((lcnt == LONG_LAST) || rst_out);
        end
    end
`else
    localparam int long_cfg_unused = LONG_W + LONG_CYCLES;
    assign rst_out = 1'b0;
`endif
endmodule

// File: tb/tb_debounce_array.sv
// Directed bench for debounce_array with STABLE_CYCLES=4 and LONG_CYCLES=10.
// Expectations track both builds of DEBOUNCE_LONGPRESS_RST_EN.

module tb_debounce_array;
`ifdef DEBOUNCE_LONGPRESS_RST_EN
    localparam logic LP = 1'b1;
`else
    localparam logic LP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [7:0] sw;
    logic [3:0] btn_out, btn_press, btn_release;
    logic [7:0] sw_out;
    logic       rst_out;

    int n_cmp = 0;
    int n_err = 0;

    debounce_array #(
        .N_BTN(4), .N_SW(8), .CNT_W(20), .STABLE_CYCLES(4),
        .LONG_W(28), .LONG_CYCLES(10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .sw         (sw),
        .btn_out    (btn_out),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_out     (sw_out),
        .rst_out    (rst_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_btn(input string tag, input logic [3:0] o, input logic [3:0] p,
                           input logic [3:0] r);
        chk({tag, "_out"}, 32'(btn_out), 32'(o));
        chk({tag, "_press"}, 32'(btn_press), 32'(p));
        chk({tag, "_release"}, 32'(btn_release), 32'(r));
    endtask

    initial begin
        // Reset with every input already asserted
        rst = 1'b1; btn = 4'hF; sw = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_btn("rst_hold", 4'h0, 4'h0, 4'h0);
            chk("rst_hold_sw", 32'(sw_out), 32'h00);
            chk("rst_hold_rstout", 32'(rst_out), 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_btn("rst_pre", 4'h0, 4'h0, 4'h0);
        chk("rst_pre_sw", 32'(sw_out), 32'h00);
        tick();
        chk_btn("rst_qual", 4'hF, 4'hF, 4'h0);
        chk("rst_qual_sw", 32'(sw_out), 32'hFF);
        tick();
        chk_btn("rst_after", 4'hF, 4'h0, 4'h0);

        // Release every button together
        btn = 4'h0;
        for (int i = 0; i < 5; i++) tick();
        chk_btn("rel_all_pre", 4'hF, 4'h0, 4'h0);
        tick();
        chk_btn("rel_all", 4'h0, 4'h0, 4'hF);
        tick();
        chk_btn("rel_all_after", 4'h0, 4'h0, 4'h0);

        // Clean press on btn[1]
        btn = 4'b0010;
        for (int i = 0; i < 5; i++) tick();
        chk_btn("press_pre", 4'h0, 4'h0, 4'h0);
        tick();
        chk_btn("press", 4'b0010, 4'b0010, 4'h0);
        tick();
        chk_btn("press_after", 4'b0010, 4'h0, 4'h0);

        // btn[2] bounces: 3 high, 3 low, five times
        for (int rep = 0; rep < 5; rep++) begin
            btn = 4'b0110;
            for (int i = 0; i < 3; i++) begin tick(); chk_btn("bounce_hi", 4'b0010, 4'h0, 4'h0); end
            btn = 4'b0010;
            for (int i = 0; i < 3; i++) begin tick(); chk_btn("bounce_lo", 4'b0010, 4'h0, 4'h0); end
        end
        for (int i = 0; i < 6; i++) begin tick(); chk_btn("bounce_tail", 4'b0010, 4'h0, 4'h0); end

        // btn[1] falls while btn[3] rises
        btn = 4'b1000;
        for (int i = 0; i < 5; i++) tick();
        chk_btn("swap_pre", 4'b0010, 4'h0, 4'h0);
        tick();
        chk_btn("swap", 4'b1000, 4'b1000, 4'b0010);
        tick();
        chk_btn("swap_after", 4'b1000, 4'h0, 4'h0);

        // Switch pattern, then a 2-cycle glitch on sw[0]
        sw = 8'hA5;
        for (int i = 0; i < 5; i++) tick();
        chk("sw_pre", 32'(sw_out), 32'hFF);
        tick();
        chk("sw_a5", 32'(sw_out), 32'hA5);
        sw = 8'hA4;
        tick(); tick();
        sw = 8'hA5;
        for (int i = 0; i < 8; i++) begin tick(); chk("sw_glitch", 32'(sw_out), 32'hA5); end

        // Long hold of btn[0]
        btn = 4'b1001;
        for (int i = 0; i < 6; i++) tick();
        chk_btn("lp_rise", 4'b1001, 4'b0001, 4'h0);
        for (int i = 1; i < 10; i++) begin tick(); chk("lp_wait", 32'(rst_out), 32'h0); end
        tick();
        chk("lp_assert", 32'(rst_out), 32'(LP));
        for (int i = 0; i < 4; i++) begin tick(); chk("lp_hold", 32'(rst_out), 32'(LP)); end
        btn = 4'b1000;
        for (int i = 0; i < 5; i++) tick();
        chk("lp_pre_fall", 32'(rst_out), 32'(LP));
        tick();
        chk_btn("lp_fall", 4'b1000, 4'h0, 4'b0001);
        chk("lp_fall_edge", 32'(rst_out), 32'(LP));
        tick();
        chk("lp_drop", 32'(rst_out), 32'h0);

        // 9-cycle hold must never raise rst_out
        btn = 4'b1001;
        for (int i = 0; i < 9; i++) begin tick(); chk("short_hold", 32'(rst_out), 32'h0); end
        btn = 4'b1000;
        for (int i = 0; i < 12; i++) begin tick(); chk("short_tail", 32'(rst_out), 32'h0); end
        chk_btn("short_end", 4'b1000, 4'h0, 4'h0);

        // One-cycle reset mid-operation, inputs held
        rst = 1'b1;
        tick();
        chk_btn("mid_rst", 4'h0, 4'h0, 4'h0);
        chk("mid_rst_sw", 32'(sw_out), 32'h00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk_btn("mid_pre", 4'h0, 4'h0, 4'h0);
        tick();
        chk_btn("mid_qual", 4'b1000, 4'b1000, 4'h0);
        chk("mid_qual_sw", 32'(sw_out), 32'hA5);
        tick();
        chk_btn("mid_after", 4'b1000, 4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
